// File: rtl/axi_pack_pkg.sv
// Shared types for the axi_pack SSR address path: beat length/size encodings,
// the affine/indirect stream descriptor and the address-generator FSM states.
package axi_pack_pkg;

  localparam int unsigned IndexOffsetWidth = 17;

  typedef logic [2:0] size_t;
  typedef logic [7:0] len_t;

  typedef struct packed {
    logic [15:0] stride;
    logic [15:0] nest_stride;
    len_t        nest_len;
  } affine_t;

  typedef struct packed {
    logic [IndexOffsetWidth-1:0] index_base_offset;
    size_t                       index_size;
  } indirect_t;

  typedef struct packed {
    logic      indirect_enable;
    affine_t   affine;
    indirect_t indirect;
  } ssr_user_t;

  typedef enum logic {
    SSR_AG_IDLE = 1'b0,
    SSR_AG_RUN  = 1'b1
  } ssr_ag_state_e;

endpackage

// File: rtl/axi_pack_ssr_step.sv
// Combinational step selector: picks the byte increment between consecutive
// beats and flags when the affine group counter sits on a nesting boundary.
module axi_pack_ssr_step
  import axi_pack_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 indirect_enable,
  input  affine_t              affine,
  input  size_t                index_size,
  input  size_t                size,
  input  len_t                 grp,
  output logic [AddrWidth-1:0] incr,
  output logic                 boundary
);

  // NOTE: every output of this always_comb is given a default first so no
  // path through the if/else can leave a value held, which would infer a latch.
  always_comb begin
    incr     = '0;
    boundary = 1'b0;
    if (indirect_enable) begin
      incr = AddrWidth'(1) << index_size;
    end else begin
      boundary = (affine.nest_len != '0) && (grp == affine.nest_len);
      // Strides are unsigned element counts, widened before scaling by size.
      incr = (boundary ? AddrWidth'(affine.nest_stride) : AddrWidth'(affine.stride)) << size;
    end
  end

endmodule

// File: rtl/axi_pack_ssr_addr_gen.sv
// Burst-to-beat address generator: accepts one affine or indirect burst
// descriptor and emits one byte address per downstream handshake.
module axi_pack_ssr_addr_gen
  import axi_pack_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  len_t                 req_len_i,
  input  size_t                req_size_i,
  input  ssr_user_t            req_user_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output len_t                 beat_idx_o,
  output logic                 beat_last_o,
  output logic                 beat_indirect_o,
  output logic                 busy_o
);

  ssr_ag_state_e        state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  len_t                 idx_q, grp_q, len_q;
  size_t                size_q, index_size_q;
  affine_t              affine_q;
  logic                 indirect_q;

  logic [AddrWidth-1:0] incr;
  logic                 boundary;
  logic                 accept, beat_hs, last;

  // The index base offset travels with the descriptor but is consumed elsewhere.
  logic unused_index_base_offset;
  assign unused_index_base_offset = ^req_user_i.indirect.index_base_offset;

  assign req_ready_o     = (state_q == SSR_AG_IDLE);
  assign busy_o          = (state_q == SSR_AG_RUN);
  assign beat_valid_o    = (state_q == SSR_AG_RUN);
  assign beat_addr_o     = addr_q;
  assign beat_idx_o      = idx_q;
  assign beat_indirect_o = indirect_q;

  assign last        = (idx_q == len_q);
  assign beat_last_o = last;
  assign accept      = req_valid_i && req_ready_o;
  assign beat_hs     = beat_valid_o && beat_ready_i;

  axi_pack_ssr_step #(
    .AddrWidth(AddrWidth)
  ) i_step (
    .indirect_enable(indirect_q),
    .affine         (affine_q),
    .index_size     (index_size_q),
    .size           (size_q),
    .grp            (grp_q),
    .incr           (incr),
    .boundary       (boundary)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SSR_AG_IDLE: if (accept) state_d = SSR_AG_RUN;
      SSR_AG_RUN:  if (beat_hs && last) state_d = SSR_AG_IDLE;
      default:     state_d = SSR_AG_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SSR_AG_IDLE;
      addr_q       <= '0;
      idx_q        <= '0;
      grp_q        <= '0;
      len_q        <= '0;
      size_q       <= '0;
      index_size_q <= '0;
      affine_q     <= '0;
      indirect_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= req_addr_i;
        idx_q        <= '0;
        grp_q        <= '0;
        len_q        <= req_len_i;
        size_q       <= req_size_i;
        index_size_q <= req_user_i.indirect.index_size;
        affine_q     <= req_user_i.affine;
        indirect_q   <= req_user_i.indirect_enable;
      end else if (beat_hs && !last) begin
        addr_q <= addr_q + incr;
        idx_q  <= idx_q + len_t'(1);
        // The group counter only tracks affine nesting; indirect bursts leave it alone.
        if (!indirect_q) grp_q <= boundary ? '0 : grp_q + len_t'(1);
      end
    end
  end

endmodule
